run_detector: RTL and testbench
===============================

# run_detector

Parametrised run-length detector, the next generation of the team's fixed-length Mealy sequence detector. It watches a qualified serial bit stream and flags the cycle in which a run of RUN_LEN identical bits completes. Run polarity (0, 1, both, none) and overlapping versus non-overlapping detection are selectable at run time. It provides both a Mealy (same-cycle) and a registered detect output plus a saturating match counter, and sits in the serial front-end ahead of the framing and statistics logic.

## Interface
- RUN_LEN, default 3: run length to detect; legal range ≥ 2. The default reproduces the legacy detector: third identical bit, either polarity.
- CNT_W, default 8: width of the match counter.
- RC_W, derived as $clog2(RUN_LEN): width of the run counter. Not user-set.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. State is cleared while rst=0.
- din_valid  input  1  qualifies din_bit; state advances only when 1.
- din_bit  input  1  serial data bit.
- mode  input  2  00 detects 0-runs, 01 detects 1-runs, 10 detects both, 11 is disabled (no hits).
- overlap  input  1  1 = every further identical bit after a completed run also hits; 0 = a new full run is required after each hit.
- clr_cnt  input  1  synchronous clear of match_cnt.
- dout_bit  output  1  Mealy hit, combinational from state and inputs.
- dout_reg  output  1  dout_bit registered; one cycle later.
- run_cnt  output  RC_W  current run count, 0 to RUN_LEN-1.
- match_cnt  output  CNT_W  saturating count of hits.

## Operation
- State registers:
  - last_bit: last accepted bit.
  - run_cnt: number of consecutive identical accepted bits ending at last_bit, saturating at RUN_LEN-1. run_cnt=0 means no previous bit.
  - dout_reg.
  - match_cnt.
- Hit (dout_bit) = din_valid & (run_cnt==RUN_LEN-1) & (din_bit==last_bit) & mode_en(din_bit).
  - mode_en is 1 for din_bit=0 with mode 00 or 10, and for din_bit=1 with mode 01 or 10. Otherwise it is 0.
- On a clock edge with din_valid=1, last_bit <= din_bit. run_cnt updates as follows:
  - run_cnt==0 or din_bit!=last_bit: run_cnt <= 1.
  - Same bit, run_cnt<RUN_LEN-1: run_cnt <= run_cnt+1.
  - Same bit, run_cnt==RUN_LEN-1, no hit (mode masks the bit): run_cnt holds.
  - Hit with overlap=1: run_cnt holds at RUN_LEN-1.
  - Hit with overlap=0: run_cnt <= 0, so the next bit starts a fresh run.
- din_valid=0: run_cnt, last_bit and match_cnt hold, and dout_bit=0.
- Run tracking is independent of mode. A mode change takes effect on dout_bit in the same cycle and never disturbs run_cnt.
- match_cnt rules:
  - Increments on a hit.
  - Saturates at 2^CNT_W-1.
  - clr_cnt=1 forces 0 on the edge and has priority over a simultaneous hit; that hit is not counted.
- Legacy equivalence: with RUN_LEN=3, mode=10, overlap=1, din_valid=1, the block behaves as the legacy states start / once / twice map to run_cnt 0 / 1 / 2.

## Timing
- Reset (rst=0, asynchronous): run_cnt=0, last_bit=0, dout_reg=0, match_cnt=0.
  - dout_bit is 0 during reset because run_cnt=0.
  - Reset mid-run discards the run. After release, RUN_LEN fresh identical bits are needed for a hit.
- dout_bit has zero-cycle latency: it is valid in the cycle the completing bit is presented.
- dout_reg follows dout_bit with one cycle of latency.
- match_cnt and run_cnt reflect a hit one cycle after it.
- Minimum hit spacing:
  - overlap=1: one cycle per accepted bit.
  - overlap=0: RUN_LEN accepted bits.
- Gaps in din_valid do not break a run. Only a differing accepted bit does.

## Structure
- Shared include run_det_defs.vh holds the mode encodings: MODE_ZERO=2'b00, MODE_ONE=2'b01, MODE_BOTH=2'b10, MODE_OFF=2'b11.
- Sub-module sat_counter (parameter W; inputs inc and clr, with clr priority; output q) implements match_cnt. It is reusable by the statistics block.
- run_detector holds run tracking, hit logic and dout_reg. A parameter check flags RUN_LEN<2 at elaboration.

## Test plan
- Reset behaviour: hold rst=0 mid-run with run_cnt=2, then release and feed 0,0,0 (RUN_LEN=3, mode=10). Expect all outputs 0 during reset, dout_bit=1 only on the third 0, and match_cnt=1 on the next cycle.
- Overlap comparison: feed 1×6 with mode=01, RUN_LEN=3.
  - overlap=1: hits on bits 3, 4, 5, 6 and match_cnt=4.
  - overlap=0: hits on bits 3 and 6 and match_cnt=2.
- Mode masking and polarity switch: feed 0,0,0,1,1,1 with mode=00. Expect a hit on bit 3 only. Switch mode to 01 while run_cnt=2 on 1s; the next 1 hits immediately.
- Valid gaps: feed 1, gap, 1, gap, gap, 1 (RUN_LEN=3). Expect a hit on the third valid 1. Then feed 1,0,1 and expect no hit, with run_cnt ending at 1.
- Counter saturation and clear: with CNT_W=2 and overlap=1, drive 5 hits and expect match_cnt to saturate at 3. Assert clr_cnt together with a hit; expect match_cnt=0 while dout_bit=1 and dout_reg=1 the next cycle.
- Parameter sweep: RUN_LEN ∈ {2,3,5,8} with a random stream, checked against a reference model of the hit rule for dout_bit, dout_reg and match_cnt.

Source files
------------

// File: rtl/run_detector_pkg.sv
// Shared definitions for the run-length detector: run polarity encodings and
// the polarity-enable rule used by the hit logic.
package run_detector_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO = 2'b00,
        MODE_ONE  = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_OFF  = 2'b11
    } mode_e;

    function automatic logic mode_en(input logic [1:0] mode, input logic bit_val);
        logic en;
        en = 1'b0;
        if (mode == MODE_BOTH)
            en = 1'b1;
        else if (mode == MODE_ZERO)
            en = !bit_val;
        else if (mode == MODE_ONE)
            en = bit_val;
        return en;
    endfunction

endpackage

// File: rtl/run_detector_if.sv
// Serial-stream side of the run detector: qualified input bit, run-time
// controls, and the Mealy/registered detect plus status counters.
interface run_detector_if #(
    parameter int RUN_LEN = 3,
    parameter int CNT_W   = 8
);
    localparam int RC_W = $clog2(RUN_LEN);

    logic             din_valid;
    logic             din_bit;
    logic [1:0]       mode;
    logic             overlap;
    logic             clr_cnt;
    logic             dout_bit;
    logic             dout_reg;
    logic [RC_W-1:0]  run_cnt;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output din_valid, din_bit, mode, overlap, clr_cnt,
        input  dout_bit, dout_reg, run_cnt, match_cnt
    );

    modport slave (
        input  din_valid, din_bit, mode, overlap, clr_cnt,
        output dout_bit, dout_reg, run_cnt, match_cnt
    );

endinterface

// File: rtl/run_detector_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// One-cycle latency from inc/clr to q; never wraps.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_q <= '0;
        else if (clr)
            r_q <= '0;
        else if (inc && (r_q != '1))
            r_q <= r_q + 1'b1;
    end

    assign q = r_q;

endmodule

// File: rtl/run_detector.sv
// Run-length detector: flags the accepted bit that completes RUN_LEN identical bits.
// dout_bit is same-cycle (Mealy); dout_reg, run_cnt and match_cnt lag by one cycle.
module run_detector
    import run_detector_pkg::*;
#(
    parameter int RUN_LEN = 3,
    parameter int CNT_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    run_detector_if.slave bus
);

    localparam int              RC_W   = $clog2(RUN_LEN);
    localparam logic [RC_W-1:0] RC_MAX = RC_W'(RUN_LEN - 1);

    if (RUN_LEN < 2) begin : g_run_len_check
        $error("run_detector: RUN_LEN must be at least 2");
    end

    logic            r_last_bit;
    logic [RC_W-1:0] r_run_cnt;
    logic            r_dout_reg;

    logic             w_same;
    logic             w_full;
    logic             w_hit;
    logic [RC_W-1:0]  w_run_nxt;
    logic [CNT_W-1:0] w_match_cnt;

    // run_cnt==0 means no prior bit, so nothing can be "the same" yet.
    assign w_same = (r_run_cnt != '0) && (bus.din_bit == r_last_bit);
    assign w_full = (r_run_cnt == RC_MAX);
    assign w_hit  = bus.din_valid && w_same && w_full && mode_en(bus.mode, bus.din_bit);

    always_comb begin
        w_run_nxt = r_run_cnt;
        if (!w_same)
            w_run_nxt = RC_W'(1);
        else if (!w_full)
            w_run_nxt = r_run_cnt + 1'b1;
        else if (w_hit && !bus.overlap)
            w_run_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_bit <= 1'b0;
            r_run_cnt  <= '0;
            r_dout_reg <= 1'b0;
        end else begin
            r_dout_reg <= w_hit;
            if (bus.din_valid) begin
                r_last_bit <= bus.din_bit;
                r_run_cnt  <= w_run_nxt;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_hit),
        .clr (bus.clr_cnt),
        .q   (w_match_cnt)
    );

    assign bus.dout_bit  = w_hit;
    assign bus.dout_reg  = r_dout_reg;
    assign bus.run_cnt   = r_run_cnt;
    assign bus.match_cnt = w_match_cnt;

endmodule

// File: tb/tb_run_detector.sv
// Directed and swept checks of run_detector against hand-derived values and a
// small run-length model for RUN_LEN 2/3/5/8.
module tb_run_detector;

    logic       clk;
    logic       rst;
    logic       t_valid;
    logic       t_bit;
    logic [1:0] t_mode;
    logic       t_ov;
    logic       t_clr;

    int n_cmp = 0;
    int n_err = 0;

    logic smp_hit;
    logic smp_hit_s;

    run_detector_if #(.RUN_LEN(3), .CNT_W(8)) m_if ();
    run_detector_if #(.RUN_LEN(3), .CNT_W(2)) q_if ();
    run_detector_if #(.RUN_LEN(2), .CNT_W(8)) s2_if ();
    run_detector_if #(.RUN_LEN(5), .CNT_W(8)) s5_if ();
    run_detector_if #(.RUN_LEN(8), .CNT_W(8)) s8_if ();

    run_detector #(.RUN_LEN(3), .CNT_W(8)) u_main (.clk(clk), .rst(rst), .bus(m_if));
    run_detector #(.RUN_LEN(3), .CNT_W(2)) u_sat  (.clk(clk), .rst(rst), .bus(q_if));
    run_detector #(.RUN_LEN(2), .CNT_W(8)) u_s2   (.clk(clk), .rst(rst), .bus(s2_if));
    run_detector #(.RUN_LEN(5), .CNT_W(8)) u_s5   (.clk(clk), .rst(rst), .bus(s5_if));
    run_detector #(.RUN_LEN(8), .CNT_W(8)) u_s8   (.clk(clk), .rst(rst), .bus(s8_if));

    assign m_if.din_valid  = t_valid;
    assign m_if.din_bit    = t_bit;
    assign m_if.mode       = t_mode;
    assign m_if.overlap    = t_ov;
    assign m_if.clr_cnt    = t_clr;
    assign q_if.din_valid  = t_valid;
    assign q_if.din_bit    = t_bit;
    assign q_if.mode       = t_mode;
    assign q_if.overlap    = t_ov;
    assign q_if.clr_cnt    = t_clr;
    assign s2_if.din_valid = t_valid;
    assign s2_if.din_bit   = t_bit;
    assign s2_if.mode      = t_mode;
    assign s2_if.overlap   = t_ov;
    assign s2_if.clr_cnt   = t_clr;
    assign s5_if.din_valid = t_valid;
    assign s5_if.din_bit   = t_bit;
    assign s5_if.mode      = t_mode;
    assign s5_if.overlap   = t_ov;
    assign s5_if.clr_cnt   = t_clr;
    assign s8_if.din_valid = t_valid;
    assign s8_if.din_bit   = t_bit;
    assign s8_if.mode      = t_mode;
    assign s8_if.overlap   = t_ov;
    assign s8_if.clr_cnt   = t_clr;

    // Sweep instances gathered by index: RUN_LEN 2, 3, 5, 8.
    logic       s_hit[4];
    logic       s_reg[4];
    logic [7:0] s_cnt[4];
    logic [3:0] s_run[4];

    assign s_hit[0] = s2_if.dout_bit;
    assign s_hit[1] = m_if.dout_bit;
    assign s_hit[2] = s5_if.dout_bit;
    assign s_hit[3] = s8_if.dout_bit;
    assign s_reg[0] = s2_if.dout_reg;
    assign s_reg[1] = m_if.dout_reg;
    assign s_reg[2] = s5_if.dout_reg;
    assign s_reg[3] = s8_if.dout_reg;
    assign s_cnt[0] = s2_if.match_cnt;
    assign s_cnt[1] = m_if.match_cnt;
    assign s_cnt[2] = s5_if.match_cnt;
    assign s_cnt[3] = s8_if.match_cnt;
    assign s_run[0] = 4'(s2_if.run_cnt);
    assign s_run[1] = 4'(m_if.run_cnt);
    assign s_run[2] = 4'(s5_if.run_cnt);
    assign s_run[3] = 4'(s8_if.run_cnt);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one input cycle, sample the Mealy outputs before the edge,
    // then land 1 time unit after the edge so registered outputs are settled.
    task automatic cyc(input logic v, input logic b);
        t_valid = v;
        t_bit   = b;
        #2;
        smp_hit   = m_if.dout_bit;
        smp_hit_s = q_if.dout_bit;
        @(posedge clk);
        #1;
    endtask

    function automatic logic ref_en(input logic [1:0] mode, input logic b);
        return (mode == 2'b10) || (mode == 2'b00 && !b) || (mode == 2'b01 && b);
    endfunction

    int   rl[4];
    int   m_len[4];
    logic m_last[4];
    int   m_cnt[4];
    logic eh[4];

    initial begin
        logic [5:0] hv;
        logic [5:0] pat;
        logic [2:0] hv3;
        int         nhit;

        rl[0] = 2; rl[1] = 3; rl[2] = 5; rl[3] = 8;
        rst = 1'b0; t_valid = 1'b0; t_bit = 1'b0;
        t_mode = 2'b10; t_ov = 1'b1; t_clr = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_run_cnt",   32'(m_if.run_cnt),   0);
        chk("rst_dout_reg",  32'(m_if.dout_reg),  0);
        chk("rst_match_cnt", 32'(m_if.match_cnt), 0);
        chk("rst_dout_bit",  32'(m_if.dout_bit),  0);
        rst = 1'b1;

        // Reset mid-run discards the run
        cyc(1'b1, 1'b0);
        chk("pre_hit1", 32'(smp_hit), 0);
        cyc(1'b1, 1'b0);
        chk("pre_run2", 32'(m_if.run_cnt), 2);
        t_valid = 1'b1; t_bit = 1'b0;
        #1; rst = 1'b0; #1;
        chk("midrst_dout_bit",  32'(m_if.dout_bit),  0);
        chk("midrst_run_cnt",   32'(m_if.run_cnt),   0);
        chk("midrst_dout_reg",  32'(m_if.dout_reg),  0);
        chk("midrst_match_cnt", 32'(m_if.match_cnt), 0);
        @(posedge clk);
        #1;
        chk("inrst_run_cnt",  32'(m_if.run_cnt),  0);
        chk("inrst_dout_bit", 32'(m_if.dout_bit), 0);
        rst = 1'b1;
        hv = '0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0);
            hv[i] = smp_hit;
        end
        chk("post_rst_hits",  32'(hv),             32'b100);
        chk("post_rst_match", 32'(m_if.match_cnt), 1);
        chk("post_rst_reg",   32'(m_if.dout_reg),  1);

        // Overlap on, six 1s with mode 01
        t_clr = 1'b1; cyc(1'b0, 1'b0); t_clr = 1'b0;
        chk("clr_match", 32'(m_if.match_cnt), 0);
        t_mode = 2'b01; t_ov = 1'b1;
        hv = '0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b1);
            hv[i] = smp_hit;
        end
        chk("ov1_hits",  32'(hv),             32'b111100);
        chk("ov1_match", 32'(m_if.match_cnt), 4);

        // Overlap off: a 0 (masked by mode 01) restarts the run first
        t_clr = 1'b1; cyc(1'b1, 1'b0); t_clr = 1'b0;
        t_ov = 1'b0;
        hv = '0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b1);
            hv[i] = smp_hit;
        end
        chk("ov0_hits",  32'(hv),             32'b100100);
        chk("ov0_match", 32'(m_if.match_cnt), 2);
        chk("ov0_run",   32'(m_if.run_cnt),   0);

        // Mode masking, then same-cycle polarity switch
        t_mode = 2'b00; t_ov = 1'b1;
        t_clr = 1'b1; cyc(1'b0, 1'b0); t_clr = 1'b0;
        pat = 6'b111000;
        hv = '0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, pat[i]);
            hv[i] = smp_hit;
        end
        chk("mask_hits", 32'(hv),           32'b000100);
        chk("mask_run",  32'(m_if.run_cnt), 2);
        t_valid = 1'b1; t_bit = 1'b1;
        #2;
        chk("switch_before", 32'(m_if.dout_bit), 0);
        t_mode = 2'b01;
        #1;
        chk("switch_after", 32'(m_if.dout_bit), 1);
        @(posedge clk);
        #1;
        chk("switch_match", 32'(m_if.match_cnt), 2);
        chk("switch_reg",   32'(m_if.dout_reg),  1);

        // Valid gaps do not break a run
        t_ov = 1'b0;
        cyc(1'b1, 1'b0);
        pat = 6'b100101;
        hv = '0;
        for (int i = 0; i < 6; i++) begin
            cyc(pat[i], 1'b1);
            hv[i] = smp_hit;
            if (i == 4)
                chk("gap_run_hold", 32'(m_if.run_cnt), 2);
        end
        chk("gap_hits", 32'(hv), 32'b100000);
        hv3 = '0;
        pat = 6'b000101;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, pat[i]);
            hv3[i] = smp_hit;
        end
        chk("alt_hits", 32'(hv3),           0);
        chk("alt_run",  32'(m_if.run_cnt),  1);

        // Saturation on the 2-bit counter, then clear beating a hit
        t_mode = 2'b10; t_ov = 1'b1;
        t_clr = 1'b1; cyc(1'b0, 1'b1); t_clr = 1'b0;
        cyc(1'b1, 1'b1);
        nhit = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1);
            nhit += int'(smp_hit_s);
        end
        chk("sat_hits",       nhit,                5);
        chk("sat_match",      32'(q_if.match_cnt), 3);
        chk("sat_wide_match", 32'(m_if.match_cnt), 5);
        t_clr = 1'b1; cyc(1'b1, 1'b1); t_clr = 1'b0;
        chk("clrhit_dout_bit", 32'(smp_hit_s),       1);
        chk("clrhit_match",    32'(q_if.match_cnt),  0);
        chk("clrhit_reg",      32'(q_if.dout_reg),   1);

        // Random sweep against the run-length model
        t_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            m_len[k] = 0; m_last[k] = 1'b0; m_cnt[k] = 0;
            chk($sformatf("sw%0d_rst_run", rl[k]), 32'(s_run[k]), 0);
            chk($sformatf("sw%0d_rst_cnt", rl[k]), 32'(s_cnt[k]), 0);
        end
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) t_bit = ~t_bit;
            t_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) t_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) t_ov = ~t_ov;
            t_clr = ($urandom_range(0, 31) == 0);
            #2;
            for (int k = 0; k < 4; k++) begin
                eh[k] = t_valid && (m_len[k] >= rl[k] - 1) && (t_bit == m_last[k])
                        && ref_en(t_mode, t_bit);
                chk($sformatf("sw%0d_dout_bit", rl[k]), 32'(s_hit[k]), 32'(eh[k]));
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (t_clr)
                    m_cnt[k] = 0;
                else if (eh[k] && m_cnt[k] < 255)
                    m_cnt[k]++;
                if (t_valid) begin
                    if (m_len[k] == 0 || t_bit != m_last[k])
                        m_len[k] = 1;
                    else if (eh[k] && !t_ov)
                        m_len[k] = 0;
                    else
                        m_len[k]++;
                    m_last[k] = t_bit;
                end
                chk($sformatf("sw%0d_dout_reg", rl[k]), 32'(s_reg[k]), 32'(eh[k]));
                chk($sformatf("sw%0d_match", rl[k]), 32'(s_cnt[k]), m_cnt[k]);
                chk($sformatf("sw%0d_run", rl[k]), 32'(s_run[k]),
                    (m_len[k] < rl[k] - 1) ? m_len[k] : rl[k] - 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
